// File: rtl/backprop_engine.sv
// backprop_engine
// Time-multiplexed backpropagation weight update for one neuron. A single
// fixed-point datapath sweeps one weight per cycle, producing the back-chained
// error for the previous layer and the updated weight, with saturation.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           run request, accepted when busy=0
//   busy            run in progress (ERR/SWEEP)
//   done            one-cycle pulse, all outputs coherent
//   x_in            N_IN activations, entry i at [i*W +: W]
//   w_in            N_IN+1 weights, entry N_IN is the bias weight
//   delta, lr       neuron error term and learning rate
//   bc_out          back-chained errors bc[i] = w[i]*delta
//   wn_out          updated weights
//   sat             sticky saturation flag for the current run
//
// state | meaning
// IDLE  | waiting for start
// ERR   | g = lr*delta registered
// SWEEP | one weight entry per cycle, idx = 0..N_IN (N_IN is the bias)
// DONE  | done pulse, may accept the next start directly
module backprop_engine #(
    parameter int N_IN = 32,
    parameter int W    = 32,
    parameter int FRAC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [N_IN*W-1:0]     x_in,
    input  logic [(N_IN+1)*W-1:0] w_in,
    input  logic [W-1:0]          delta,
    input  logic [W-1:0]          lr,
    output logic [N_IN*W-1:0]     bc_out,
    output logic [(N_IN+1)*W-1:0] wn_out,
    output logic                  sat
);

    localparam int IW = $clog2(N_IN + 1);
    localparam int XW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [W-1:0] ONE = {{(W-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

    typedef enum logic [1:0] {IDLE, ERR, SWEEP, DONE} state_t;

    state_t state, state_nx;
    logic   accept;

    logic [IW-1:0] idx;
    logic [XW-1:0] xi;
    logic          last;

    logic signed [W-1:0] x_r  [N_IN];
    logic signed [W-1:0] w_r  [N_IN+1];
    logic signed [W-1:0] bc_r [N_IN];
    logic signed [W-1:0] wn_r [N_IN+1];
    logic signed [W-1:0] delta_r, lr_r, g_r;

    logic signed [W-1:0] x_sel, w_sel;
    logic [W:0]          g_res, bc_res, up_res, wn_res;

    // Returns {clamped, value} for sat_W((a*b) >>> FRAC) with a full 2W product.
    function automatic logic [W:0] scale(input logic signed [W-1:0] a,
                                         input logic signed [W-1:0] b);
        logic signed [2*W-1:0] p;
        logic signed [2*W-1:0] s;
        p = (2*W)'(a) * (2*W)'(b);
        s = p >>> FRAC;
        if (s[2*W-1:W-1] == {(W+1){s[2*W-1]}})
            return {1'b0, s[W-1:0]};
        else if (s[2*W-1])
            return {1'b1, 1'b1, {(W-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(W-1){1'b1}}};
    endfunction

    // Returns {clamped, value} for a - b clamped to W bits.
    function automatic logic [W:0] satsub(input logic signed [W-1:0] a,
                                          input logic signed [W-1:0] b);
        logic [W:0] d;
        d = {a[W-1], a} - {b[W-1], b};
        if (d[W] == d[W-1])
            return {1'b0, d[W-1:0]};
        else if (d[W])
            return {1'b1, 1'b1, {(W-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(W-1){1'b1}}};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = ERR;
                end
            end
            ERR: begin
                busy     = 1'b1;
                state_nx = SWEEP;
            end
            SWEEP: begin
                busy = 1'b1;
                if (last)
                    state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = ERR;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign last = (idx == IW'(N_IN));
    assign xi   = idx[XW-1:0];

    // The bias entry sees an input of exactly 1.0, so its update term is g
    // itself and the shared scale path needs no special case.
    assign x_sel  = last ? ONE : x_r[xi];
    assign w_sel  = w_r[idx];
    assign g_res  = scale(lr_r, delta_r);
    assign bc_res = scale(w_sel, delta_r);
    assign up_res = scale(g_r, x_sel);
    assign wn_res = satsub(w_sel, up_res[W-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                x_r[i]  <= '0;
                bc_r[i] <= '0;
            end
            for (int i = 0; i <= N_IN; i++) begin
                w_r[i]  <= '0;
                wn_r[i] <= '0;
            end
            delta_r <= '0;
            lr_r    <= '0;
            g_r     <= '0;
            idx     <= '0;
            sat     <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < N_IN; i++)
                    x_r[i] <= x_in[i*W +: W];
                for (int i = 0; i <= N_IN; i++)
                    w_r[i] <= w_in[i*W +: W];
                delta_r <= delta;
                lr_r    <= lr;
                idx     <= '0;
                sat     <= 1'b0;
            end
            if (state == ERR) begin
                g_r <= g_res[W-1:0];
                idx <= '0;
                if (g_res[W])
                    sat <= 1'b1;
            end
            if (state == SWEEP) begin
                wn_r[idx] <= wn_res[W-1:0];
                if (!last)
                    bc_r[xi] <= bc_res[W-1:0];
                if (wn_res[W] || up_res[W] || (!last && bc_res[W]))
                    sat <= 1'b1;
                idx <= idx + IW'(1);
            end
        end
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_bc
        assign bc_out[i*W +: W] = bc_r[i];
    end
    for (genvar i = 0; i <= N_IN; i++) begin : g_wn
        assign wn_out[i*W +: W] = wn_r[i];
    end

endmodule

// File: doc/backprop_engine.md
# backprop_engine

Parametrised, time-multiplexed backpropagation weight-update engine for one neuron. It takes N_IN input activations, N_IN+1 weights (index N_IN is the threshold/bias weight), the neuron's error term and a learning rate. It produces back-chained errors for the previous layer and updated weights. The block replaces the fully parallel per-weight array with one shared fixed-point datapath that sweeps one weight per cycle, and adds saturation and a start/done handshake. It sits between the neuron-layer error stage and the weight store.

## Interface
- N_IN, 32, number of input weights; the bias weight is extra.
- W, 32, data width; all values are signed two's complement.
- FRAC, 16, fractional bits (Q(W-FRAC).FRAC); 1.0 = 1<<FRAC.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse; all outputs valid.
- x_in  in  N_IN*W  input activations; entry i is bits [i*W +: W].
- w_in  in  (N_IN+1)*W  current weights; entry N_IN is the bias weight.
- delta  in  W  error term of this neuron.
- lr  in  W  learning rate.
- bc_out  out  N_IN*W  back-chained error; bc[i] = w[i]*delta.
- wn_out  out  (N_IN+1)*W  updated weights.
- sat  out  1  sticky; set if any saturation occurred in the current run.

## Operation
- FSM states: IDLE, ERR, SWEEP, DONE.
- IDLE with start=1:
  - Capture x_in, w_in, delta and lr into internal registers.
  - Clear sat.
  - Go to ERR. Inputs may change freely after acceptance.
- ERR: g = sat_W((lr*delta) >>> FRAC). Then go to SWEEP with idx=0.
- SWEEP for idx < N_IN:
  - bc[idx] = sat_W((w[idx]*delta) >>> FRAC)
  - wn[idx] = satsub(w[idx], sat_W((g*x[idx]) >>> FRAC))
- SWEEP at idx = N_IN (bias, input fixed at 1.0): wn[N_IN] = satsub(w[N_IN], g). Then go to DONE.
- DONE: done=1 for this cycle only. Go to IDLE, or go straight to ERR if start=1 (accepted).
- Arithmetic rules:
  - Products are full 2W-bit signed.
  - >>> is an arithmetic shift, so the result floors toward −inf.
  - sat_W clamps to [−2^(W−1), 2^(W−1)−1].
  - satsub is W-bit subtraction clamped the same way.
  - Any clamp sets sat.
- start while busy=1 is ignored. No queuing.
- Output entries are written in place during a sweep. They are guaranteed coherent only from done until the next run's sweep overwrites them.
- Reset:
  - All outputs, internal registers and idx go to 0; state goes to IDLE; busy=0, done=0, sat=0.
  - Reset mid-run abandons the run. No done is produced.

## Timing
- Let start be sampled high at edge k (state IDLE).
  - Edge k: busy rises.
  - Edge k+1: g registered.
  - Edge k+2+i: entry i written, for i = 0..N_IN.
  - Edge k+N_IN+2: done rises and busy falls, at the same edge as the bias write.
- Total latency is N_IN+2 cycles; 34 cycles at the defaults.
- Throughput: a start held high in the done cycle is accepted at the next edge. Back-to-back runs therefore take N_IN+3 cycles each.
- Outputs and sat change only on clock edges, except for asynchronous reset.

## Test plan
- Basic update (FRAC=16): lr=0x8000, delta=0x10000, all x=0x10000, all w=0x20000.
  - Required at done: every bc=0x20000; every wn (bias included) = 0x18000; sat=0.
  - done arrives exactly 34 cycles after acceptance.
- Saturation: w[0]=0x7FFF0000, delta=0x20000.
  - Required: bc[0]=0x7FFFFFFF and sat=1.
  - Separately, w[5]=0x80000000 with g*x[5]>0: wn[5]=0x80000000.
- Floor rounding: w[3]=0xFFFFFFFF, delta=0x8000.
  - Required: bc[3]=0xFFFFFFFF (−1 LSB, not 0).
- Handshake:
  - Pulse start again at cycle k+5: ignored, only one done.
  - Hold start high through done: second run accepted at the next edge; second done at k+2·(N_IN+3)−1.
  - sat is cleared at the second acceptance.
- Reset mid-sweep: assert rst at cycle k+10.
  - Required immediately: busy=0, done=0, sat=0, all outputs 0.
  - After deassertion with no new start, done never asserts.
- Input isolation: change x_in, w_in and lr every cycle after acceptance.
  - Required: results match the values captured at acceptance.
